spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised SPI slave; successor to the fixed 8-bit, mode-0 slave.
- Adds configurable word width, all four SPI modes and bit order.
- Adds a TX holding register with valid/ready handshake, an RX strobe, and underrun and abort reporting.
- Sits between an external SPI master pin interface and on-chip logic. All logic runs on the fast system clock; SCK is oversampled, never used as a clock.

Parameters:
- DATA_W, 8: bits per SPI word (4..32).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- MSB_FIRST, 1: 1 = MSB first on both MOSI and MISO; 0 = LSB first.
- SYNC_STAGES, 2: synchroniser flops on sck/ssel_n/mosi (>=2).
- DUMMY, {DATA_W{1'b1}}: word transmitted on TX underrun.

Ports:
- clk  in  1  system clock; must be >= 4x SCK frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from master.
- ssel_n  in  1  slave select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  MISO output enable (high while selected).
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle strobe, rx_data updated.
- tx_underrun  out  1  one-cycle strobe: DUMMY loaded because holding register empty.
- frame_abort  out  1  one-cycle strobe: ssel_n deasserted with partial word.
- busy  out  1  frame in progress.

Behaviour:
- Reset (async assert, sync release): all synchronisers load idle values (sck=CPOL, ssel_n=1, mosi=0).
  - Shift registers, bit counter, holding register and rx_data = 0.
  - tx_ready=1; rx_valid, tx_underrun, frame_abort, busy, miso_oe, miso = 0.
- Synchronisation and edge detection:
  - Each input passes SYNC_STAGES flops; edges are detected between the last two stages.
  - Leading edge = SCK idle->active transition (rising if CPOL=0); trailing edge = active->idle.
  - sample_edge = leading if CPHA=0, else trailing; shift_edge = the other edge.
- State machine, IDLE/ACTIVE:
  - IDLE->ACTIVE on synchronised ssel_n falling. bitcnt=0, busy=1, miso_oe=1.
    - If CPHA=0, the TX shift register is loaded in that same cycle.
  - ACTIVE->IDLE on synchronised ssel_n rising, or on any cycle ssel_n is synchronised high.
- Bit counter: width $clog2(DATA_W); increments on each sample_edge; wraps DATA_W-1 -> 0. Frames carry any number of back-to-back words.
- RX path:
  - On sample_edge, mosi is shifted in (left if MSB_FIRST, else right).
  - When the sample completes bit DATA_W-1, the next clk cycle sets rx_data to the full word and pulses rx_valid for 1 cycle.
  - rx_data holds until the next complete word. There is no backpressure; the consumer must accept within one word time.
- TX load points:
  - CPHA=0: at ssel_n falling, and on the shift_edge where bitcnt==0 (after the last sample of a word); other shift_edges shift.
  - CPHA=1: on the leading edge with bitcnt==0; other shift_edges shift.
  - miso = shift-register MSB (MSB_FIRST) or LSB. Remains stable between shift_edges.
- TX load source and handshake:
  - Load takes the holding register if full; the holding register is then emptied and tx_ready=1 the next cycle.
  - If the holding register is empty, DUMMY is loaded and tx_underrun pulses.
  - A write happens when tx_valid&&tx_ready; tx_ready = !hold_full.
  - A load and a write in the same cycle: the load takes the old content or DUMMY; the new word is stored and tx_ready=0 next cycle.
  - The holding register is writable in IDLE, so the first word can be preloaded.
- Deselect:
  - If bitcnt!=0 at ssel_n rise, frame_abort pulses and the partial RX word is discarded (no rx_valid).
  - bitcnt=0, miso_oe=0, miso=0, busy=0; the holding register is retained.
- Simultaneous ssel_n rise and sample_edge in the same cycle: deselect wins; the edge is ignored.
- Reset mid-frame: immediate return to reset values; no strobes are generated.

Test Plan:
- Mode 0, DATA_W=8, preload tx 0x3C, master sends 0xA5: rx_valid once with rx_data=0xA5; master reads 0x3C; tx_ready returns to 1 after the load.
- Mode 3 (CPOL=1, CPHA=1), 2-word frame, tx 0x81 then 0x7E written during word 0, master sends 0x12,0x34: rx_valid twice (0x12, 0x34); MISO 0x81, 0x7E; no tx_underrun.
- DATA_W=16, MSB_FIRST=0, mode 1, master sends 0xBEEF LSB-first, tx 0x1234: rx_data=0xBEEF; MISO bit sequence is 0x1234 LSB-first.
- No tx_valid before frame, mode 0: tx_underrun pulses at ssel_n fall; master reads 0xFF.
- ssel_n deasserted after 5 of 8 SCK cycles, then a new full frame with 0x5A: frame_abort once, no rx_valid for the partial word; the second frame gives rx_data=0x5A.
- rst_n pulsed low mid-word: all outputs return to reset values asynchronously; the next frame after release transfers correctly.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave with configurable word width, mode and bit order. SCK, SSEL_N and MOSI are
// oversampled on clk, and a holding register with a valid/ready handshake feeds the TX shifter.
module spi_slave_param #(
  parameter int                DATA_W      = 8,
  parameter bit                CPOL        = 1'b0,
  parameter bit                CPHA        = 1'b0,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DUMMY       = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ssel_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy,
  output logic              o_dbg_state
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ssel_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [CNT_W-1:0]       r_bitcnt;
  logic [DATA_W-1:0]      r_rx_shift;
  logic [DATA_W-1:0]      r_tx_shift;
  logic [DATA_W-1:0]      r_hold;
  logic                   r_hold_full;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid;
  logic                   r_underrun;
  logic                   r_abort;

  logic              w_sck_old, w_sck_new, w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic              w_ssel_fall, w_ssel_high, w_mosi;
  logic              w_go_active, w_deselect, w_do_sample, w_do_load, w_do_shift, w_write;
  logic              w_tx_bit;
  logic [DATA_W-1:0] w_rx_next;
  logic [DATA_W-1:0] w_tx_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= {SYNC_STAGES{CPOL}};
      r_ssel_sync <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], ssel_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  // Edges are seen between the last two stages; stage SYNC_STAGES-2 is the newer value.
  assign w_sck_old     = r_sck_sync[SYNC_STAGES-1];
  assign w_sck_new     = r_sck_sync[SYNC_STAGES-2];
  assign w_lead        = (w_sck_old == CPOL) && (w_sck_new != CPOL);
  assign w_trail       = (w_sck_old != CPOL) && (w_sck_new == CPOL);
  assign w_sample_edge = CPHA ? w_trail : w_lead;
  assign w_shift_edge  = CPHA ? w_lead : w_trail;
  assign w_ssel_fall   = r_ssel_sync[SYNC_STAGES-1] && !r_ssel_sync[SYNC_STAGES-2];
  assign w_ssel_high   = r_ssel_sync[SYNC_STAGES-2];
  assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];

  assign w_rx_next    = MSB_FIRST ? {r_rx_shift[DATA_W-2:0], w_mosi}
                                  : {w_mosi, r_rx_shift[DATA_W-1:1]};
  assign w_tx_shifted = MSB_FIRST ? {r_tx_shift[DATA_W-2:0], 1'b0}
                                  : {1'b0, r_tx_shift[DATA_W-1:1]};
  assign w_tx_bit     = MSB_FIRST ? r_tx_shift[DATA_W-1] : r_tx_shift[0];

  // TX handshake: a word is accepted on any clk where tx_valid && tx_ready; tx_ready is
  // simply "holding register empty" and does not depend on tx_valid.
  assign w_write = tx_valid && !r_hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_active = 1'b0;
    w_deselect  = 1'b0;
    w_do_sample = 1'b0;
    w_do_load   = 1'b0;
    w_do_shift  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ssel_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_go_active = 1'b1;
          w_do_load   = (CPHA == 1'b0);
        end
      end
      ST_ACTIVE: begin
        // Deselect takes priority over any SCK edge seen in the same cycle.
        if (w_ssel_high) begin
          w_state_nxt = ST_IDLE;
          w_deselect  = 1'b1;
        end else begin
          w_do_sample = w_sample_edge;
          if (w_shift_edge) begin
            if (r_bitcnt == '0) w_do_load  = 1'b1;
            else                w_do_shift = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt    <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      if (w_go_active) r_bitcnt <= '0;
      if (w_deselect) begin
        r_bitcnt   <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= '0;
        r_abort    <= (r_bitcnt != '0);
      end
      if (w_do_sample) begin
        r_rx_shift <= w_rx_next;
        if (r_bitcnt == LAST_BIT) begin
          r_bitcnt   <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
      end
      if (w_do_load) begin
        r_tx_shift <= r_hold_full ? r_hold : DUMMY;
        r_underrun <= !r_hold_full;
      end else if (w_do_shift) begin
        r_tx_shift <= w_tx_shifted;
      end
      // A write can only coincide with a load when the register was empty, so the load
      // has already taken DUMMY and the new word simply fills the register.
      if (w_write) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_do_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == ST_ACTIVE);
  assign miso_oe     = (r_state == ST_ACTIVE);
  assign miso        = (r_state == ST_ACTIVE) && w_tx_bit;
  assign tx_ready    = !r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign frame_abort = r_abort;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: three instances (mode 0 8-bit, mode 3 8-bit, mode 1 16-bit LSB-first)
// driven by a bit-level SPI master task and checked against a word-level frame model.
module tb_spi_slave_param;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck_raw = 1'b0;
  logic        mosi = 1'b0;
  logic [2:0]  ssel_v = 3'b111;
  logic [2:0]  txv_v = 3'b000;
  logic [31:0] tx_data = 32'h0;
  logic [2:0]  miso_v, oe_v, rdy_v, rxv_v, und_v, abt_v, busy_v, st_v;
  logic [7:0]  rxd0, rxd1;
  logic [15:0] rxd2;
  logic [1:0]  cur_d = 2'd0;
  logic        rxv_m, und_m, abt_m;
  logic [31:0] rxd_m;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_under = 0;
  int          n_abort = 0;
  logic [31:0] rx_q[$];
  logic [31:0] miso_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_words[5];
  logic [31:0] t_words[5];
  bit          t_have[5];

  int cfg_w[3]    = '{8, 8, 16};
  bit cfg_cpha[3] = '{1'b0, 1'b1, 1'b1};
  bit cfg_msb[3]  = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck_raw), .ssel_n(ssel_v[0]), .mosi(mosi),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx_data[7:0]), .tx_valid(txv_v[0]),
    .tx_ready(rdy_v[0]), .rx_data(rxd0), .rx_valid(rxv_v[0]), .tx_underrun(und_v[0]),
    .frame_abort(abt_v[0]), .busy(busy_v[0]), .o_dbg_state(st_v[0]));

  spi_slave_param #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sck(~sck_raw), .ssel_n(ssel_v[1]), .mosi(mosi),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(tx_data[7:0]), .tx_valid(txv_v[1]),
    .tx_ready(rdy_v[1]), .rx_data(rxd1), .rx_valid(rxv_v[1]), .tx_underrun(und_v[1]),
    .frame_abort(abt_v[1]), .busy(busy_v[1]), .o_dbg_state(st_v[1]));

  spi_slave_param #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sck(sck_raw), .ssel_n(ssel_v[2]), .mosi(mosi),
    .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(tx_data[15:0]), .tx_valid(txv_v[2]),
    .tx_ready(rdy_v[2]), .rx_data(rxd2), .rx_valid(rxv_v[2]), .tx_underrun(und_v[2]),
    .frame_abort(abt_v[2]), .busy(busy_v[2]), .o_dbg_state(st_v[2]));

  always_comb begin
    rxv_m = rxv_v[cur_d];
    und_m = und_v[cur_d];
    abt_m = abt_v[cur_d];
    case (cur_d)
      2'd0:    rxd_m = {24'h0, rxd0};
      2'd1:    rxd_m = {24'h0, rxd1};
      default: rxd_m = {16'h0, rxd2};
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rxv_m) rx_q.push_back(rxd_m);
      if (und_m) n_under++;
      if (abt_m) n_abort++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input int d, input logic [31:0] data);
    int k;
    k = 0;
    tx_data  = data;
    txv_v[d] = 1'b1;
    while (!rdy_v[d] && k < 50) begin
      wait_clk(1);
      k++;
    end
    if (k == 50) chk("tx_ready_timeout", 32'(rdy_v[d]), 32'd1);
    wait_clk(1);
    txv_v[d] = 1'b0;
  endtask

  task automatic clear_words();
    for (int i = 0; i < 5; i++) begin
      m_words[i] = 32'h0;
      t_words[i] = 32'h0;
      t_have[i]  = 1'b0;
    end
  endtask

  // One frame of nwords full words plus an optional partial word of `partial` bits.
  task automatic spi_frame(input int d, input int nwords, input int partial);
    int          loads, nb, idx, exp_under;
    logic [31:0] got, mask;
    mask  = (32'h1 << cfg_w[d]) - 32'h1;
    loads = nwords + ((partial > 0 || !cfg_cpha[d]) ? 1 : 0);
    cur_d = 2'(d);
    rx_q.delete();
    miso_q.delete();
    n_under = 0;
    n_abort = 0;
    if (t_have[0]) tx_write(d, t_words[0]);
    ssel_v[d] = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nwords + ((partial > 0) ? 1 : 0); i++) begin
      nb  = (i < nwords) ? cfg_w[d] : partial;
      got = 32'h0;
      for (int b = 0; b < nb; b++) begin
        idx  = cfg_msb[d] ? cfg_w[d] - 1 - b : b;
        mosi = m_words[i][idx];
        if (!cfg_cpha[d]) begin
          wait_clk(HALF);
          got[idx] = miso_v[d];
          sck_raw = 1'b1;
          wait_clk(HALF);
          sck_raw = 1'b0;
        end else begin
          sck_raw = 1'b1;
          wait_clk(HALF);
          got[idx] = miso_v[d];
          sck_raw = 1'b0;
          wait_clk(HALF);
        end
        if (b == 2 && i + 1 < loads && t_have[i+1]) tx_write(d, t_words[i+1]);
      end
      if (i < nwords) miso_q.push_back(got);
    end
    mosi = 1'b0;
    wait_clk(HALF);
    ssel_v[d] = 1'b1;
    wait_clk(10);

    exp_q.delete();
    for (int i = 0; i < nwords; i++) exp_q.push_back(m_words[i] & mask);
    chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rx_q.size() > 0) chk("rx_data", rx_q.pop_front(), exp_q.pop_front());
    if (nwords > 0) chk("rx_hold", rxd_m, m_words[nwords-1] & mask);
    exp_q.delete();
    for (int i = 0; i < nwords; i++) exp_q.push_back(t_have[i] ? (t_words[i] & mask) : mask);
    while (exp_q.size() > 0 && miso_q.size() > 0) chk("miso_word", miso_q.pop_front(), exp_q.pop_front());
    exp_under = 0;
    for (int i = 0; i < loads; i++) if (!t_have[i]) exp_under++;
    chk("underrun_cnt", 32'(n_under), 32'(exp_under));
    chk("abort_cnt", 32'(n_abort), (partial > 0) ? 32'd1 : 32'd0);
    chk("tx_ready_end", 32'(rdy_v[d]), 32'd1);
    chk("busy_end", 32'(busy_v[d]), 32'd0);
    chk("oe_end", 32'(oe_v[d]), 32'd0);
    chk("miso_end", 32'(miso_v[d]), 32'd0);
  endtask

  task automatic rand_frame(input int d);
    int nw, part;
    nw   = $urandom_range(1, 3);
    part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cfg_w[d] - 1) : 0;
    for (int i = 0; i < 5; i++) begin
      m_words[i] = $urandom;
      t_words[i] = $urandom;
      t_have[i]  = ($urandom_range(0, 3) != 0);
    end
    spi_frame(d, nw, part);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      cur_d = 2'(d);
      #1;
      chk("rst_tx_ready", 32'(rdy_v[d]), 32'd1);
      chk("rst_busy", 32'(busy_v[d]), 32'd0);
      chk("rst_oe", 32'(oe_v[d]), 32'd0);
      chk("rst_miso", 32'(miso_v[d]), 32'd0);
      chk("rst_rx_data", rxd_m, 32'd0);
      chk("rst_strobes", {29'h0, rxv_m, und_m, abt_m}, 32'd0);
    end
    #3 rst_n = 1'b1;
    wait_clk(4);

    clear_words(); t_words[0] = 32'h3C; t_have[0] = 1'b1; m_words[0] = 32'hA5;
    spi_frame(0, 1, 0);
    clear_words(); t_words[0] = 32'h81; t_words[1] = 32'h7E; t_have[0] = 1'b1; t_have[1] = 1'b1;
    m_words[0] = 32'h12; m_words[1] = 32'h34;
    spi_frame(1, 2, 0);
    clear_words(); t_words[0] = 32'h1234; t_have[0] = 1'b1; m_words[0] = 32'hBEEF;
    spi_frame(2, 1, 0);
    clear_words(); m_words[0] = $urandom;
    spi_frame(0, 1, 0);
    clear_words(); m_words[0] = $urandom;
    spi_frame(0, 0, 5);
    clear_words(); m_words[0] = 32'h5A; t_words[0] = $urandom; t_have[0] = 1'b1;
    spi_frame(0, 1, 0);

    clear_words();
    cur_d = 2'd0;
    tx_write(0, 32'h66);
    rx_q.delete(); n_under = 0; n_abort = 0;
    ssel_v[0] = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'($urandom);
      wait_clk(HALF);
      sck_raw = 1'b1;
      wait_clk(HALF);
      sck_raw = 1'b0;
    end
    chk("busy_pre_rst", 32'(busy_v[0]), 32'd1);
    sck_raw = 1'b1;
    wait_clk(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy_v[0]), 32'd0);
    chk("async_oe", 32'(oe_v[0]), 32'd0);
    chk("async_miso", 32'(miso_v[0]), 32'd0);
    chk("async_tx_ready", 32'(rdy_v[0]), 32'd1);
    chk("async_rx_data", rxd_m, 32'd0);
    sck_raw = 1'b0; ssel_v[0] = 1'b1; mosi = 1'b0;
    #7 rst_n = 1'b1;
    wait_clk(10);
    chk("post_rst_abort", 32'(n_abort), 32'd0);
    chk("post_rst_rx", 32'(rx_q.size()), 32'd0);
    chk("post_rst_under", 32'(n_under), 32'd0);
    clear_words(); m_words[0] = $urandom; t_words[0] = $urandom; t_have[0] = 1'b1;
    spi_frame(0, 1, 0);

    for (int n = 0; n < 15; n++) rand_frame($urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
